// File: rtl/ifetch_unit.sv
// Multi-cycle instruction-fetch stage: architectural PC, req/ready fetch of the
// word at PC into the instruction register, and a sticky alignment/timeout fault.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_we,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cpc,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic        fault
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_FAULT
    } state_t;

    state_t        state, state_d;
    logic [31:0]   pc;
    logic [CW-1:0] cnt, cnt_d;
    logic          pc_load;
    logic          ins_load;
    logic          ins_valid_d;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pc_load     = 1'b0;
        ins_load    = 1'b0;
        ins_valid_d = ins_valid;
        case (state)
            S_IDLE, S_VALID: begin
                if (pc_we && (npc[1:0] != 2'b00)) begin
                    state_d     = S_FAULT;
                    ins_valid_d = 1'b0;
                end else begin
                    // A new PC invalidates the IR; fetch_en in the same cycle fetches from the new PC.
                    if (pc_we) begin
                        pc_load     = 1'b1;
                        ins_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                    if (fetch_en) begin
                        state_d     = S_REQ;
                        ins_valid_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
            end
            S_REQ: begin
                if (imem_ready) begin
                    ins_load    = 1'b1;
                    ins_valid_d = 1'b1;
                    state_d     = S_VALID;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                ins_valid_d = 1'b0;
            end
            default: begin
                state_d     = S_FAULT;
                ins_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            ins       <= '0;
            ins_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (pc_load) begin
                pc <= npc;
            end
            if (ins_load) begin
                ins <= imem_rdata;
            end
            ins_valid <= ins_valid_d;
            cnt       <= cnt_d;
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign cpc       = pc;
    assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch latency, PC update rules, wait states,
// watchdog boundary, alignment fault and asynchronous reset.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        pc_we;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] cpc;
    logic [31:0] ins;
    logic        ins_valid;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_unit #(
        .RESET_PC(32'h0000_3000),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .pc_we     (pc_we),
        .npc       (npc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .cpc       (cpc),
        .ins       (ins),
        .ins_valid (ins_valid),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b1;
        fetch_en   = 1'b0;
        pc_we      = 1'b0;
        npc        = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_req",   imem_req,  32'd0);
        check("rst_cpc",   cpc,       32'h0000_3000);
        check("rst_ins",   ins,       32'd0);
        check("rst_valid", ins_valid, 32'd0);
        check("rst_fault", fault,     32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Basic fetch: ready in first REQ cycle
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("f1_req",   imem_req,  32'd1);
        check("f1_addr",  imem_addr, 32'h0000_3000);
        check("f1_valid", ins_valid, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h2010_0005;
        tick();
        imem_ready = 1'b0;
        check("f1_ins",    ins,       32'h2010_0005);
        check("f1_valid2", ins_valid, 32'd1);
        check("f1_req2",   imem_req,  32'd0);

        // PC update in VALID, then fetch from new PC
        pc_we = 1'b1;
        npc   = 32'h0000_3004;
        tick();
        pc_we = 1'b0;
        check("pcwe_cpc",   cpc,       32'h0000_3004);
        check("pcwe_valid", ins_valid, 32'd0);
        check("pcwe_ins",   ins,       32'h2010_0005);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("f2_req",  imem_req,  32'd1);
        check("f2_addr", imem_addr, 32'h0000_3004);

        // Three wait cycles; pc_we during REQ must be ignored
        pc_we = 1'b1;
        npc   = 32'h0000_4000;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("wait_req", imem_req, 32'd1);
            check("wait_cpc", cpc,      32'h0000_3004);
            check("wait_ins", ins,      32'h2010_0005);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hAABB_CC01;
        tick();
        imem_ready = 1'b0;
        pc_we      = 1'b0;
        check("wait_ins2",  ins,       32'hAABB_CC01);
        check("wait_valid", ins_valid, 32'd1);
        check("wait_req2",  imem_req,  32'd0);
        check("wait_cpc2",  cpc,       32'h0000_3004);

        // Ready on the 16th REQ cycle is accepted
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("to16_req", imem_req, 32'd1);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ready = 1'b0;
        check("to16_valid", ins_valid, 32'd1);
        check("to16_fault", fault,     32'd0);
        check("to16_ins",   ins,       32'h1234_5678);

        // Async reset in the middle of REQ
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        check("ar_req_pre", imem_req, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_req",   imem_req,  32'd0);
        check("ar_cpc",   cpc,       32'h0000_3000);
        check("ar_ins",   ins,       32'd0);
        check("ar_valid", ins_valid, 32'd0);
        #2 reset = 1'b1;

        // Simultaneous pc_we + fetch_en: REQ at new PC
        pc_we    = 1'b1;
        fetch_en = 1'b1;
        npc      = 32'h0000_3010;
        tick();
        pc_we    = 1'b0;
        fetch_en = 1'b0;
        check("sim_req",  imem_req,  32'd1);
        check("sim_addr", imem_addr, 32'h0000_3010);
        check("sim_cpc",  cpc,       32'h0000_3010);
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        tick();
        imem_ready = 1'b0;
        check("sim_ins",   ins,       32'hCAFE_0001);
        check("sim_valid", ins_valid, 32'd1);

        // Misaligned npc: sticky fault, PC held, later requests ignored
        pc_we = 1'b1;
        npc   = 32'h0000_3006;
        tick();
        pc_we = 1'b0;
        check("mis_fault", fault,     32'd1);
        check("mis_cpc",   cpc,       32'h0000_3010);
        check("mis_valid", ins_valid, 32'd0);
        fetch_en   = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        fetch_en   = 1'b0;
        imem_ready = 1'b0;
        check("mis_req",    imem_req,  32'd0);
        check("mis_fault2", fault,     32'd1);
        check("mis_ins",    ins,       32'hCAFE_0001);
        check("mis_valid2", ins_valid, 32'd0);

        // Reset clears fault; then no ready for 16 REQ cycles -> timeout fault
        #2 reset = 1'b0;
        #1;
        check("rst2_fault", fault, 32'd0);
        #2 reset = 1'b1;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("to_req",    imem_req, 32'd1);
            check("to_nofault", fault,   32'd0);
        end
        tick();
        check("to_fault", fault,     32'd1);
        check("to_req2",  imem_req,  32'd0);
        check("to_valid", ins_valid, 32'd0);
        check("to_cpc",   cpc,       32'h0000_3000);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("to_fault2", fault, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
